// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the instruction-fetch controller
package if_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        FULL = 2'd3
    } fetch_state_t;

    localparam int INSTR_BYTES = 4;

    // Low address bits cleared to force word alignment
    localparam logic [1:0] ALIGN_LOW_MASK = 2'b11;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// rtl/if_fetch_ctrl_if.sv - imem request/response, redirect and decode handshake bundle
interface if_fetch_ctrl_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_instr;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output if_valid,
        input  if_ready,
        output if_pc,
        output if_instr
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  if_valid,
        output if_ready,
        input  if_pc,
        input  if_instr
    );

endinterface

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - single-outstanding instruction fetch controller driving the PC register
module if_fetch_ctrl
    import if_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [XLEN-1:0] i_pc_q,
    output logic [XLEN-1:0] o_pc_next,
    output logic            o_pc_we,
    if_fetch_ctrl_if.master bus
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic            r_kill;
    logic            w_kill_next;

    logic            r_if_valid;
    logic            w_if_valid_next;
    logic [XLEN-1:0] r_if_pc;
    logic [XLEN-1:0] r_if_instr;
    logic            w_capture;

    logic            w_req;
    logic [XLEN-1:0] w_addr;
    logic            w_redirect;
    logic [XLEN-1:0] w_pc_aligned;
    logic [XLEN-1:0] w_redirect_aligned;

    assign w_pc_aligned       = i_pc_q & ~XLEN'(ALIGN_LOW_MASK);
    assign w_redirect_aligned = bus.redirect_pc & ~XLEN'(ALIGN_LOW_MASK);

    // BOOT owns the PC write, so a redirect there is not honoured
    assign w_redirect = bus.redirect_valid && (r_state != BOOT);

    always_comb begin
        w_state_next    = r_state;
        w_kill_next     = r_kill;
        w_if_valid_next = r_if_valid;
        w_capture       = 1'b0;
        w_req           = 1'b0;
        w_addr          = '0;
        o_pc_we         = 1'b0;
        o_pc_next       = i_pc_q;

        case (r_state)
            BOOT: begin
                o_pc_we      = 1'b1;
                o_pc_next    = RESET_PC;
                w_state_next = REQ;
            end
            REQ: begin
                w_req  = !bus.redirect_valid;
                w_addr = w_pc_aligned;
                if (w_req && bus.imem_gnt) begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (bus.imem_rvalid) begin
                    w_kill_next = 1'b0;
                    if (!r_kill && !w_redirect) begin
                        w_capture       = 1'b1;
                        w_if_valid_next = 1'b1;
                        o_pc_we         = 1'b1;
                        o_pc_next       = i_pc_q + XLEN'(INSTR_BYTES);
                        w_state_next    = FULL;
                    end else begin
                        w_state_next = REQ;
                    end
                end else if (w_redirect) begin
                    // Response still owed by memory; mark it for discard
                    w_kill_next = 1'b1;
                end
            end
            FULL: begin
                if (w_redirect || bus.if_ready) begin
                    w_if_valid_next = 1'b0;
                    w_state_next    = REQ;
                end
            end
            default: begin
                w_state_next = BOOT;
            end
        endcase

        if (w_redirect) begin
            o_pc_we   = 1'b1;
            o_pc_next = w_redirect_aligned;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= BOOT;
            r_kill  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_kill  <= w_kill_next;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_if_valid <= 1'b0;
            r_if_pc    <= '0;
            r_if_instr <= '0;
        end else begin
            r_if_valid <= w_if_valid_next;
            if (w_capture) begin
                r_if_pc    <= i_pc_q;
                r_if_instr <= bus.imem_rdata;
            end
        end
    end

    assign bus.imem_req  = w_req;
    assign bus.imem_addr = w_addr;
    assign bus.if_valid  = r_if_valid;
    assign bus.if_pc     = r_if_pc;
    assign bus.if_instr  = r_if_instr;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - self-checking bench for if_fetch_ctrl with PC register and memory models
module tb_if_fetch_ctrl;

    localparam logic [31:0] RST_PC      = 32'h0000_0100;
    localparam logic [31:0] FIRST_INSTR = 32'h0050_0093;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic        pc_we;

    if_fetch_ctrl_if #(.XLEN(32)) bus();

    if_fetch_ctrl #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .i_pc_q    (pc_q),
        .o_pc_next (pc_next),
        .o_pc_we   (pc_we),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)    pc_q <= '0;
        else if (pc_we) pc_q <= pc_next;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int mem_lat = 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h100) ? FIRST_INSTR : (a ^ 32'h1300_0013);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: no event within cycle budget, expected one (cycle %0d)", name, cyc);
    endtask

    // Memory: one response mem_lat cycles after the grant cycle, cancelled by reset
    int          mem_pend  = 0;
    logic [31:0] mem_paddr = '0;
    logic        mem_nrv;

    initial begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        forever begin
            @(negedge clk);
            mem_nrv = 1'b0;
            if (!resetn) begin
                mem_pend = 0;
            end else begin
                if (bus.imem_req && bus.imem_gnt) begin
                    mem_pend  = mem_lat;
                    mem_paddr = bus.imem_addr;
                end
                if (mem_pend > 0) begin
                    mem_pend--;
                    if (mem_pend == 0) mem_nrv = 1'b1;
                end
            end
            @(posedge clk);
            #2;
            bus.imem_rvalid = mem_nrv;
            bus.imem_rdata  = mem_nrv ? mem_word(mem_paddr) : 32'hDEAD_BEEF;
        end
    end

    // Reference model: booting / request outstanding / buffer occupied
    logic        m_boot = 1'b1;
    logic        m_busy = 1'b0;
    logic        m_kill = 1'b0;
    logic        m_full = 1'b0;
    logic [31:0] m_pc   = '0;
    logic [31:0] m_old;
    logic        e_redir, e_req, e_take, e_we;
    logic [31:0] e_next;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!resetn) begin
                m_boot = 1'b1; m_busy = 1'b0; m_kill = 1'b0; m_full = 1'b0; m_pc = '0;
            end
            e_redir = bus.redirect_valid && !m_boot;
            e_req   = !m_boot && !m_busy && !m_full && !bus.redirect_valid;
            e_take  = m_busy && bus.imem_rvalid && !m_kill && !e_redir;
            e_we    = 1'b1;
            e_next  = '0;
            if (m_boot)       e_next = RST_PC;
            else if (e_redir) e_next = {bus.redirect_pc[31:2], 2'b00};
            else if (e_take)  e_next = m_pc + 32'd4;
            else              e_we   = 1'b0;

            chk("m_pc_q", pc_q, m_pc);
            chk("m_pc_we", pc_we, e_we);
            if (e_we) chk("m_pc_next", pc_next, e_next);
            chk("m_imem_req", bus.imem_req, e_req);
            if (e_req) chk("m_imem_addr", bus.imem_addr, {m_pc[31:2], 2'b00});
            chk("m_if_valid", bus.if_valid, m_full);
            if (m_full) begin
                chk("m_if_pc", bus.if_pc, m_old);
                chk("m_if_instr", bus.if_instr, mem_word(m_old));
            end

            if (resetn) begin
                if (m_boot) begin
                    m_boot = 1'b0;
                    m_pc   = RST_PC;
                end else begin
                    if (m_busy) begin
                        if (bus.imem_rvalid) begin
                            m_busy = 1'b0;
                            m_kill = 1'b0;
                            if (e_take) begin
                                m_full = 1'b1;
                                m_old  = m_pc;
                            end
                        end else if (e_redir) begin
                            m_kill = 1'b1;
                        end
                    end else if (m_full) begin
                        if (e_redir || bus.if_ready) m_full = 1'b0;
                    end else if (e_req && bus.imem_gnt) begin
                        m_busy = 1'b1;
                    end
                    if (e_we) m_pc = e_next;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_accept(output int c);
        c = -1;
        for (int k = 0; k < 40; k++) begin
            sample();
            if (bus.imem_req && bus.imem_gnt) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) timeout("wait_accept");
    endtask

    task automatic wait_valid();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            sample();
            if (bus.if_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) timeout("wait_valid");
    endtask

    initial begin
        int c0, c1, c2;
        resetn             = 1'b0;
        bus.imem_gnt       = 1'b1;
        bus.if_ready       = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        tick();
        tick();
        chk("rst_if_valid", bus.if_valid, 32'd0);
        chk("rst_if_pc", bus.if_pc, 32'd0);
        chk("rst_if_instr", bus.if_instr, 32'd0);
        chk("rst_imem_req", bus.imem_req, 32'd0);
        chk("rst_imem_addr", bus.imem_addr, 32'd0);
        chk("rst_pc_we", pc_we, 32'd1);
        chk("rst_pc_next", pc_next, RST_PC);
        tick();
        resetn = 1'b1;

        // Streaming fetch, 3-cycle cadence
        wait_accept(c0);
        chk("first_addr", bus.imem_addr, 32'h100);
        wait_valid();
        chk("first_if_pc", bus.if_pc, 32'h100);
        chk("first_if_instr", bus.if_instr, FIRST_INSTR);
        wait_accept(c1);
        chk("second_addr", bus.imem_addr, 32'h104);
        chk("cadence_1", c1 - c0, 32'd3);
        wait_accept(c2);
        chk("third_addr", bus.imem_addr, 32'h108);
        chk("cadence_2", c2 - c1, 32'd3);

        // Decode stall in FULL
        tick();
        bus.if_ready = 1'b0;
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", bus.if_valid, 32'd1);
            chk("stall_if_pc", bus.if_pc, 32'h108);
            chk("stall_if_instr", bus.if_instr, 32'h1300_011B);
            chk("stall_no_req", bus.imem_req, 32'd0);
            chk("stall_pc_q", pc_q, 32'h10C);
            sample();
        end
        tick();
        bus.if_ready = 1'b1;
        mem_lat      = 3;

        // Redirect while waiting; late response must be discarded
        wait_accept(c0);
        chk("w_redir_addr", bus.imem_addr, 32'h10C);
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        mem_lat            = 1;
        sample();
        chk("w_redir_pc_next", pc_next, 32'h200);
        tick();
        bus.redirect_valid = 1'b0;
        sample();
        chk("w_redir_pc_q", pc_q, 32'h200);
        sample();
        chk("w_kill_no_valid", bus.if_valid, 32'd0);
        sample();
        chk("w_kill_no_valid2", bus.if_valid, 32'd0);
        chk("w_redir_req", bus.imem_req, 32'd1);
        chk("w_redir_new_addr", bus.imem_addr, 32'h200);

        // Redirect in FULL with if_ready high
        tick();
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h303;
        sample();
        chk("f_valid_before", bus.if_valid, 32'd1);
        chk("f_if_pc", bus.if_pc, 32'h200);
        chk("f_if_instr", bus.if_instr, 32'h1300_0213);
        chk("f_pc_next", pc_next, 32'h300);
        tick();
        bus.redirect_valid = 1'b0;
        sample();
        chk("f_valid_dropped", bus.if_valid, 32'd0);
        chk("f_pc_q", pc_q, 32'h300);
        chk("f_next_addr", bus.imem_addr, 32'h300);

        // Redirect coincident with rvalid
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h400;
        sample();
        chk("c_pc_next", pc_next, 32'h400);
        tick();
        bus.redirect_valid = 1'b0;
        mem_lat            = 3;
        sample();
        chk("c_pc_q", pc_q, 32'h400);
        chk("c_no_valid", bus.if_valid, 32'd0);
        chk("c_next_addr", bus.imem_addr, 32'h400);

        // Asynchronous reset pulse during WAIT
        tick();
        resetn = 1'b0;
        #1;
        chk("ar_if_valid", bus.if_valid, 32'd0);
        chk("ar_imem_req", bus.imem_req, 32'd0);
        chk("ar_pc_q", pc_q, 32'd0);
        chk("ar_pc_next", pc_next, RST_PC);
        tick();
        tick();
        resetn  = 1'b1;
        mem_lat = 1;
        tick();
        bus.imem_gnt = 1'b0;
        sample();
        chk("ar_restart_pc_q", pc_q, RST_PC);
        chk("ar_restart_addr", bus.imem_addr, RST_PC);
        tick();
        bus.imem_gnt = 1'b1;
        wait_valid();
        chk("ar_if_pc", bus.if_pc, RST_PC);
        chk("ar_if_instr", bus.if_instr, FIRST_INSTR);

        tick();
        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
